ps2_key_decoder: RTL and testbench

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

---
 rtl/ps2_key_decoder_pkg.sv | 58 +++++
 rtl/ps2_key_decoder_prefix_timer.sv | 36 +++
 rtl/ps2_key_decoder.sv | 118 +++++++++++
 tb/tb_ps2_key_decoder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_key_decoder_pkg.sv
// Scan-code constants, decoder state encoding and held-key helpers.
package ps2_key_decoder_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_BAT   = 8'hAA;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_LEFT  = 8'h6B;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  typedef struct packed {
    logic w;
    logic d;
    logic a;
    logic up;
    logic right;
    logic left;
  } held_t;

  function automatic logic is_arrow(input logic [7:0] code);
    return (code == SC_UP) || (code == SC_RIGHT) || (code == SC_LEFT);
  endfunction

  function automatic held_t apply_plain(input held_t h, input logic [7:0] code, input logic val);
    held_t r;
    r = h;
    case (code)
      SC_W:    r.w = val;
      SC_D:    r.d = val;
      SC_A:    r.a = val;
      default: ;
    endcase
    return r;
  endfunction

  function automatic held_t apply_arrow(input held_t h, input logic [7:0] code, input logic val);
    held_t r;
    r = h;
    case (code)
      SC_UP:    r.up    = val;
      SC_RIGHT: r.right = val;
      SC_LEFT:  r.left  = val;
      default:  ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_prefix_timer.sv
// Saturating idle counter; flags a timeout on the cycle it is about to reach the limit.
module ps2_prefix_timer
  import ps2_key_decoder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic timeout
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q;

  // Idle counter: cleared on demand, counts while running, holds at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (run && (count_q != CNT_MAX)) begin
      count_q <= count_q + 1'b1;
    end
  end

  // The edge that would bring the count to TIMEOUT_CYCLES is the timeout edge.
  always_comb begin
    timeout = run && !clear && (count_q >= CNT_LIMIT);
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code decoder: tracks held movement keys and drives registered move levels.
module ps2_key_decoder
  import ps2_key_decoder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Enable,
  input  logic [7:0] rxData,
  input  logic       rxValid,
  output logic       moveForward,
  output logic       moveRight,
  output logic       moveLeft,
  output logic       seqError
);

  state_t state_q, state_d;
  held_t  held_q, held_d;
  logic   seq_err_d;
  logic   timeout;
  logic   timer_clear;
  logic   timer_run;
  logic   right_held_d;
  logic   left_held_d;

  assign timer_clear = !Enable || rxValid;
  assign timer_run   = Enable && (state_q != ST_IDLE);

  ps2_prefix_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_prefix_timer (
    .clk    (Clock),
    .rst_n  (Resetn),
    .clear  (timer_clear),
    .run    (timer_run),
    .timeout(timeout)
  );

  // Next-state, held-key update and error decode; a byte beats a same-cycle timeout.
  always_comb begin
    state_d   = state_q;
    held_d    = held_q;
    seq_err_d = 1'b0;
    if (!Enable) begin
      state_d = ST_IDLE;
      held_d  = '0;
    end else if (rxValid) begin
      case (state_q)
        ST_IDLE: begin
          if (rxData == SC_EXT) begin
            state_d = ST_EXT;
          end else if (rxData == SC_BREAK) begin
            state_d = ST_BRK;
          end else if (rxData == SC_BAT) begin
            held_d = '0;
          end else begin
            held_d = apply_plain(held_q, rxData, 1'b1);
          end
        end
        ST_EXT: begin
          if (rxData == SC_BREAK) begin
            state_d = ST_EXT_BRK;
          end else begin
            state_d = ST_IDLE;
            if (is_arrow(rxData)) begin
              held_d = apply_arrow(held_q, rxData, 1'b1);
            end else begin
              seq_err_d = 1'b1;
            end
          end
        end
        ST_BRK: begin
          state_d = ST_IDLE;
          held_d  = apply_plain(held_q, rxData, 1'b0);
        end
        ST_EXT_BRK: begin
          state_d = ST_IDLE;
          if (is_arrow(rxData)) begin
            held_d = apply_arrow(held_q, rxData, 1'b0);
          end else begin
            seq_err_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (timeout) begin
      state_d   = ST_IDLE;
      seq_err_d = 1'b1;
    end
  end

  // Direction arbitration on the next held state so outputs land one cycle after the byte.
  always_comb begin
    right_held_d = held_d.d || held_d.right;
    left_held_d  = held_d.a || held_d.left;
  end

  // State, held keys and registered outputs.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= ST_IDLE;
      held_q      <= '0;
      moveForward <= 1'b0;
      moveRight   <= 1'b0;
      moveLeft    <= 1'b0;
      seqError    <= 1'b0;
    end else begin
      state_q     <= state_d;
      held_q      <= held_d;
      moveForward <= held_d.w || held_d.up;
      moveRight   <= right_held_d && !left_held_d;
      moveLeft    <= left_held_d && !right_held_d;
      seqError    <= seq_err_d;
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder with TIMEOUT_CYCLES = 16.
module tb_ps2_key_decoder;

  logic       Clock;
  logic       Resetn;
  logic       Enable;
  logic [7:0] rxData;
  logic       rxValid;
  logic       moveForward;
  logic       moveRight;
  logic       moveLeft;
  logic       seqError;

  int unsigned checks;
  int unsigned failures;

  typedef struct {
    logic       en;
    logic       valid;
    logic [7:0] data;
    logic [3:0] exp;   // {fwd, right, left, err}
  } vec_t;

  vec_t vecs[$];

  ps2_key_decoder #(
    .TIMEOUT_CYCLES(16)
  ) dut (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .Enable     (Enable),
    .rxData     (rxData),
    .rxValid    (rxValid),
    .moveForward(moveForward),
    .moveRight  (moveRight),
    .moveLeft   (moveLeft),
    .seqError   (seqError)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [3:0] exp);
    logic [3:0] act;
    act = {moveForward, moveRight, moveLeft, seqError};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got fwd/right/left/err=%b required %b", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, let the posedge take it, settle, drop the strobe.
  task automatic step(input logic en, input logic valid, input logic [7:0] data);
    @(negedge Clock);
    Enable  = en;
    rxValid = valid;
    rxData  = data;
    @(posedge Clock);
    #1;
    rxValid = 1'b0;
  endtask

  task automatic add(input logic en, input logic valid, input logic [7:0] data, input logic [3:0] exp);
    vec_t v;
    v.en = en; v.valid = valid; v.data = data; v.exp = exp;
    vecs.push_back(v);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    Resetn   = 1'b0;
    Enable   = 1'b0;
    rxValid  = 1'b0;
    rxData   = 8'h00;

    // Forward press / release
    add(1, 1, 8'h1D, 4'b1000);
    add(1, 1, 8'hF0, 4'b1000);
    add(1, 1, 8'h1D, 4'b0000);
    // Right arrow, then A cancels it, release A restores right
    add(1, 1, 8'hE0, 4'b0000);
    add(1, 1, 8'h74, 4'b0100);
    add(1, 1, 8'h1C, 4'b0000);
    add(1, 1, 8'hF0, 4'b0000);
    add(1, 1, 8'h1C, 4'b0100);
    add(1, 1, 8'hE0, 4'b0100);
    add(1, 1, 8'hF0, 4'b0100);
    add(1, 1, 8'h74, 4'b0000);
    // Bad code after E0 F0 keeps held keys; typematic D
    add(1, 1, 8'h1D, 4'b1000);
    add(1, 1, 8'hE0, 4'b1000);
    add(1, 1, 8'hF0, 4'b1000);
    add(1, 1, 8'h12, 4'b1001);
    add(1, 1, 8'h23, 4'b1100);
    add(1, 1, 8'h23, 4'b1100);
    add(1, 1, 8'h23, 4'b1100);
    add(1, 1, 8'hF0, 4'b1100);
    add(1, 1, 8'h23, 4'b1000);
    add(1, 1, 8'hF0, 4'b1000);
    add(1, 1, 8'h1D, 4'b0000);
    // BAT clears all; strobe-less data ignored
    add(1, 1, 8'h1C, 4'b0010);
    add(1, 1, 8'h1D, 4'b1010);
    add(1, 0, 8'hF0, 4'b1010);
    add(1, 1, 8'hAA, 4'b0000);
    // Unknown after F0 is silent; unknown after E0 errors
    add(1, 1, 8'hF0, 4'b0000);
    add(1, 1, 8'h55, 4'b0000);
    add(1, 1, 8'hE0, 4'b0000);
    add(1, 1, 8'h12, 4'b0001);
    // Typematic left arrow then release
    add(1, 1, 8'hE0, 4'b0000);
    add(1, 1, 8'h6B, 4'b0010);
    add(1, 1, 8'hE0, 4'b0010);
    add(1, 1, 8'h6B, 4'b0010);
    add(1, 1, 8'hE0, 4'b0010);
    add(1, 1, 8'hF0, 4'b0010);
    add(1, 1, 8'h6B, 4'b0000);
    // Up arrow
    add(1, 1, 8'hE0, 4'b0000);
    add(1, 1, 8'h75, 4'b1000);
    add(1, 1, 8'hE0, 4'b1000);
    add(1, 1, 8'hF0, 4'b1000);
    add(1, 1, 8'h75, 4'b0000);
    // Enable drop clears keys and pending prefix; bytes ignored while low
    add(1, 1, 8'h1D, 4'b1000);
    add(1, 1, 8'hE0, 4'b1000);
    add(1, 1, 8'h6B, 4'b1010);
    add(0, 0, 8'h00, 4'b0000);
    add(0, 1, 8'h1D, 4'b0000);
    add(0, 1, 8'hE0, 4'b0000);
    add(1, 0, 8'h00, 4'b0000);
    add(1, 1, 8'h75, 4'b0000);
    add(1, 1, 8'h1D, 4'b1000);
    add(1, 1, 8'hF0, 4'b1000);
    add(1, 1, 8'h1D, 4'b0000);

    // Reset state
    @(posedge Clock);
    #1;
    check("reset_state", 4'b0000);
    @(negedge Clock);
    Resetn = 1'b1;
    Enable = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].valid, vecs[i].data);
      check($sformatf("vec%0d_%h", i, vecs[i].data), vecs[i].exp);
    end

    // Prefix timeout: single pulse on the 16th idle edge, then a lone 75 does nothing
    step(1, 1, 8'hE0);
    check("to_e0", 4'b0000);
    for (int k = 1; k <= 20; k++) begin
      step(1, 0, 8'h00);
      check($sformatf("to_idle%0d", k), (k == 16) ? 4'b0001 : 4'b0000);
    end
    step(1, 1, 8'h75);
    check("to_lone75", 4'b0000);

    // Byte arriving on the timeout edge wins
    step(1, 1, 8'hE0);
    for (int k = 1; k <= 15; k++) begin
      step(1, 0, 8'h00);
      check($sformatf("race_idle%0d", k), 4'b0000);
    end
    step(1, 1, 8'h75);
    check("race_75", 4'b1000);
    for (int k = 1; k <= 20; k++) begin
      step(1, 0, 8'h00);
      check($sformatf("race_after%0d", k), 4'b1000);
    end
    step(1, 1, 8'hE0);
    step(1, 1, 8'hF0);
    step(1, 1, 8'h75);
    check("race_release", 4'b0000);

    // Asynchronous reset between E0 and 75
    step(1, 1, 8'h1D);
    check("rst_hold", 4'b1000);
    step(1, 1, 8'hE0);
    check("rst_prefix", 4'b1000);
    #2;
    Resetn = 1'b0;
    #1;
    check("rst_async", 4'b0000);
    @(negedge Clock);
    Resetn = 1'b1;
    step(1, 1, 8'h75);
    check("rst_75", 4'b0000);
    for (int k = 1; k <= 20; k++) begin
      step(1, 0, 8'h00);
      check($sformatf("rst_idle%0d", k), 4'b0000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
